// File: rtl/qmem_bus_n.sv
// qmem_bus_n: single-master QMEM interconnect that routes one master to SN slaves
// through per-slave base/mask windows. Unmapped addresses get a one-cycle decode error.
// Optional watchdog: define QMEM_BUS_TIMEOUT_EN to abort a stalled slave after TMO_CNT
// wait cycles. The default build has no counter and no TOERR state.
module qmem_bus_n #(
  parameter int unsigned       MAW      = 13,
  parameter int unsigned       SAW      = 12,
  parameter int unsigned       QDW      = 32,
  parameter int unsigned       QSW      = QDW/8,
  parameter int unsigned       SN       = 4,
  parameter logic [SN*MAW-1:0] SLV_BASE = '0,
  parameter logic [SN*MAW-1:0] SLV_MASK = '0,
  parameter int unsigned       TMO_CNT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MAW-1:0]    m_adr,
  input  logic              m_cs,
  input  logic              m_we,
  input  logic [QSW-1:0]    m_sel,
  input  logic [QDW-1:0]    m_dat_w,
  output logic [QDW-1:0]    m_dat_r,
  output logic              m_ack,
  output logic              m_err,
  output logic [SN*SAW-1:0] s_adr,
  output logic [SN-1:0]     s_cs,
  output logic [SN-1:0]     s_we,
  output logic [SN*QSW-1:0] s_sel,
  output logic [SN*QDW-1:0] s_dat_w,
  input  logic [SN*QDW-1:0] s_dat_r,
  input  logic [SN-1:0]     s_ack,
  input  logic [SN-1:0]     s_err
);

  localparam int unsigned IW = (SN > 1) ? $clog2(SN) : 1;

`ifdef QMEM_BUS_TIMEOUT_EN
  localparam int unsigned CW = (TMO_CNT > 1) ? $clog2(TMO_CNT + 1) : 1;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DECERR, ST_TOERR} state_t;
  logic [CW-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DECERR} state_t;
`endif

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic [IW-1:0] sel;
  logic          err_state;

  // Address, direction, selects and write data are broadcast; only s_cs is gated.
  assign s_adr   = {SN{m_adr[SAW-1:0]}};
  assign s_we    = {SN{m_we}};
  assign s_sel   = {SN{m_sel}};
  assign s_dat_w = {SN{m_dat_w}};

  // Window decode; scanning downward makes the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = SN - 1; i >= 0; i--) begin
      if ((m_adr & SLV_MASK[i*MAW +: MAW]) == SLV_BASE[i*MAW +: MAW]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  // Slave whose response is currently forwarded: decoded in IDLE, latched in WAIT.
  assign sel = (state_q == ST_WAIT) ? idx_q : hit_idx;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
`ifdef QMEM_BUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
`ifdef QMEM_BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic: a transfer leaves IDLE only if the slave does not answer at once.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
`ifdef QMEM_BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (m_cs) begin
          if (!hit) begin
            state_d = ST_DECERR;
          end else if (!(s_ack[hit_idx] | s_err[hit_idx])) begin
            state_d = ST_WAIT;
            idx_d   = hit_idx;
`ifdef QMEM_BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ST_WAIT: begin
        if (!m_cs || s_ack[idx_q] || s_err[idx_q]) begin
          state_d = ST_IDLE;
        end else begin
`ifdef QMEM_BUS_TIMEOUT_EN
          // Counter reaches TMO_CNT in this cycle with no response: abort next cycle.
          if (cnt_q == CW'(TMO_CNT - 1)) begin
            state_d = ST_TOERR;
          end
          if (cnt_q != CW'(TMO_CNT)) begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: chip select gating and response forwarding, all forced quiet in reset.
  always_comb begin
    s_cs      = '0;
    err_state = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (m_cs && hit) begin
            s_cs[hit_idx] = 1'b1;
          end
        end
        ST_WAIT: begin
          s_cs[idx_q] = m_cs;
        end
        default: begin
          err_state = 1'b1;
        end
      endcase
    end
    m_ack   = s_ack[sel] & s_cs[sel];
    m_err   = (s_err[sel] & s_cs[sel]) | err_state;
    m_dat_r = m_ack ? s_dat_r[sel*QDW +: QDW] : '0;
  end

endmodule

// File: tb/tb_qmem_bus_n.sv
// Directed bench for qmem_bus_n: four behavioural slaves with programmable ack latency
// and response type; every cycle's expectations are written out by hand.
`timescale 1ns/1ps
module tb_qmem_bus_n;

  localparam int unsigned MAW = 13;
  localparam int unsigned SAW = 12;
  localparam int unsigned QDW = 32;
  localparam int unsigned QSW = 4;
  localparam int unsigned SN  = 4;
  localparam int unsigned TMO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [MAW-1:0]    m_adr;
  logic              m_cs;
  logic              m_we;
  logic [QSW-1:0]    m_sel;
  logic [QDW-1:0]    m_dat_w;
  logic [QDW-1:0]    m_dat_r;
  logic              m_ack;
  logic              m_err;
  logic [SN*SAW-1:0] s_adr;
  logic [SN-1:0]     s_cs;
  logic [SN-1:0]     s_we;
  logic [SN*QSW-1:0] s_sel;
  logic [SN*QDW-1:0] s_dat_w;
  logic [SN*QDW-1:0] s_dat_r;
  logic [SN-1:0]     s_ack;
  logic [SN-1:0]     s_err;

  int n_checks = 0;
  int n_errors = 0;

  // Slave models: respond when s_cs has been held lat[k] cycles; mode bit0=ack, bit1=err.
  int         lat  [SN];
  logic [1:0] mode [SN];
  int         cnt  [SN];
  logic [SN-1:0] resp;

  qmem_bus_n #(
    .MAW(MAW), .SAW(SAW), .QDW(QDW), .QSW(QSW), .SN(SN),
    .SLV_BASE({13'h1E00, 13'h1800, 13'h1000, 13'h0000}),
    .SLV_MASK({13'h1C00, 13'h1C00, 13'h1800, 13'h1000}),
    .TMO_CNT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_adr(m_adr), .m_cs(m_cs), .m_we(m_we), .m_sel(m_sel), .m_dat_w(m_dat_w),
    .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
    .s_adr(s_adr), .s_cs(s_cs), .s_we(s_we), .s_sel(s_sel), .s_dat_w(s_dat_w),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err)
  );

  always #5 clk = ~clk;

  assign s_dat_r = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF};

  always_comb begin
    resp  = '0;
    s_ack = '0;
    s_err = '0;
    for (int k = 0; k < SN; k++) begin
      resp[k]  = s_cs[k] && (lat[k] >= 0) && (cnt[k] == lat[k]);
      s_ack[k] = resp[k] & mode[k][0];
      s_err[k] = resp[k] & mode[k][1];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < SN; k++) begin
      if (!s_cs[k] || resp[k]) cnt[k] <= 0;
      else                     cnt[k] <= cnt[k] + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs change there.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational paths settle, well before the next edge.
  task automatic settle();
    #3;
  endtask

  task automatic req(input logic [MAW-1:0] adr, input logic we, input logic [QSW-1:0] sel,
                     input logic [QDW-1:0] dat);
    m_adr   = adr;
    m_we    = we;
    m_sel   = sel;
    m_dat_w = dat;
    m_cs    = 1'b1;
  endtask

  task automatic expect_bus(input string tag, input logic [SN-1:0] cs, input logic ack,
                            input logic err, input logic [QDW-1:0] dat);
    settle();
    check({tag, ".s_cs"},    64'(s_cs),    64'(cs));
    check({tag, ".m_ack"},   64'(m_ack),   64'(ack));
    check({tag, ".m_err"},   64'(m_err),   64'(err));
    check({tag, ".m_dat_r"}, 64'(m_dat_r), 64'(dat));
  endtask

  initial begin
    for (int k = 0; k < SN; k++) begin
      lat[k]  = 0;
      mode[k] = 2'b01;
    end
    rst = 1'b1;
    m_cs = 1'b0; m_adr = '0; m_we = 1'b0; m_sel = '0; m_dat_w = '0;
    next_cyc();
    next_cyc();

    // Reset holds everything quiet even with a live, decodable request.
    req(13'h0004, 1'b0, 4'hF, '0);
    expect_bus("rst_hold", 4'b0000, 1'b0, 1'b0, 32'h0);
    next_cyc();

    // Zero-wait read of slave 0 completes in the request cycle.
    rst = 1'b0;
    expect_bus("zw_read", 4'b0001, 1'b1, 1'b0, 32'hDEAD_BEEF);
    next_cyc();
    m_cs = 1'b0;
    expect_bus("zw_idle", 4'b0000, 1'b0, 1'b0, 32'h0);
    next_cyc();

    // Write to slave 2 acking after 3 waits.
    lat[2] = 3;
    req(13'h1804, 1'b1, 4'b0101, 32'h1234_5678);
    settle();
    check("wr.s_we2",    64'(s_we[2]),             64'(1'b1));
    check("wr.s_sel2",   64'(s_sel[2*QSW +: QSW]), 64'(4'b0101));
    check("wr.s_adr2",   64'(s_adr[2*SAW +: SAW]), 64'(12'h804));
    check("wr.s_dat_w2", 64'(s_dat_w[2*QDW +: QDW]), 64'(32'h1234_5678));
    next_cyc();
    for (int c = 1; c < 3; c++) begin
      expect_bus("wr_wait", 4'b0100, 1'b0, 1'b0, 32'h0);
      next_cyc();
    end
    expect_bus("wr_ack", 4'b0100, 1'b1, 1'b0, 32'h3333_3333);
    next_cyc();
    m_cs = 1'b0;
    expect_bus("wr_idle", 4'b0000, 1'b0, 1'b0, 32'h0);
    next_cyc();

    // Unmapped address: one-cycle decode error, no chip select.
    req(13'h1E00, 1'b0, 4'hF, '0);
    expect_bus("dec_c0", 4'b0000, 1'b0, 1'b0, 32'h0);
    next_cyc();
    expect_bus("dec_c1", 4'b0000, 1'b0, 1'b1, 32'h0);
    next_cyc();
    m_cs = 1'b0;
    expect_bus("dec_c2", 4'b0000, 1'b0, 1'b0, 32'h0);
    next_cyc();

    // Stalled slave.
    lat[2] = -1;
    req(13'h1804, 1'b0, 4'hF, '0);
`ifdef QMEM_BUS_TIMEOUT_EN
    for (int c = 0; c <= TMO; c++) begin
      expect_bus("tmo_wait", 4'b0100, 1'b0, 1'b0, 32'h0);
      next_cyc();
    end
    expect_bus("tmo_err", 4'b0000, 1'b0, 1'b1, 32'h0);
    next_cyc();
`else
    for (int c = 0; c < 12; c++) begin
      expect_bus("stall_wait", 4'b0100, 1'b0, 1'b0, 32'h0);
      next_cyc();
    end
`endif
    m_cs = 1'b0;
    expect_bus("stall_end", 4'b0000, 1'b0, 1'b0, 32'h0);
    next_cyc();

    // Ack arriving in wait cycle TMO beats the watchdog.
    lat[2] = TMO;
    req(13'h1804, 1'b0, 4'hF, '0);
    for (int c = 0; c < TMO; c++) begin
      expect_bus("late_wait", 4'b0100, 1'b0, 1'b0, 32'h0);
      next_cyc();
    end
    expect_bus("late_ack", 4'b0100, 1'b1, 1'b0, 32'h3333_3333);
    next_cyc();
    m_cs = 1'b0;
    expect_bus("late_after", 4'b0000, 1'b0, 1'b0, 32'h0);
    next_cyc();

    // Reset during WAIT, then a fresh request at 0x0000.
    lat[2] = -1;
    req(13'h1804, 1'b0, 4'hF, '0);
    next_cyc();
    next_cyc();
    next_cyc();
    rst = 1'b1;
    expect_bus("rst_wait", 4'b0000, 1'b0, 1'b0, 32'h0);
    next_cyc();
    rst = 1'b0;
    req(13'h0000, 1'b0, 4'hF, '0);
    expect_bus("post_rst", 4'b0001, 1'b1, 1'b0, 32'hDEAD_BEEF);
    next_cyc();
    m_cs = 1'b0;
    next_cyc();

    // Back-to-back zero-wait requests to slaves 0 then 1.
    req(13'h0004, 1'b0, 4'hF, '0);
    expect_bus("b2b_0", 4'b0001, 1'b1, 1'b0, 32'hDEAD_BEEF);
    next_cyc();
    m_adr = 13'h1004;
    expect_bus("b2b_1", 4'b0010, 1'b1, 1'b0, 32'h2222_2222);
    next_cyc();
    m_cs = 1'b0;
    next_cyc();

    // Master drops m_cs during WAIT: no response, bus usable next.
    req(13'h1804, 1'b0, 4'hF, '0);
    next_cyc();
    m_cs = 1'b0;
    expect_bus("abandon", 4'b0000, 1'b0, 1'b0, 32'h0);
    next_cyc();
    req(13'h0004, 1'b0, 4'hF, '0);
    expect_bus("abandon_next", 4'b0001, 1'b1, 1'b0, 32'hDEAD_BEEF);
    next_cyc();
    m_cs = 1'b0;
    next_cyc();

    // Slave error after one wait is forwarded, no ack, no data.
    lat[1]  = 1;
    mode[1] = 2'b10;
    req(13'h1004, 1'b0, 4'hF, '0);
    expect_bus("serr_c0", 4'b0010, 1'b0, 1'b0, 32'h0);
    next_cyc();
    expect_bus("serr_c1", 4'b0010, 1'b0, 1'b1, 32'h0);
    next_cyc();
    m_cs = 1'b0;
    next_cyc();

    // Ack and err raised together are both forwarded.
    mode[0] = 2'b11;
    req(13'h0008, 1'b0, 4'hF, '0);
    expect_bus("ackerr", 4'b0001, 1'b1, 1'b1, 32'hDEAD_BEEF);
    next_cyc();
    m_cs = 1'b0;
    next_cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
